// File: rtl/ace_ccu_snoop_resp_collect_if.sv
// Handshake bundle between the CCU snoop issue logic, the snooped CR channels
// and the merged-response consumer of ace_ccu_snoop_resp_collect.
interface ace_ccu_snoop_resp_collect_if #(
  parameter int unsigned NoMst = 4
);
  logic                 start_valid_i;
  logic                 start_ready_o;
  logic [NoMst-1:0]     start_mask_i;
  logic [NoMst-1:0]     cr_valid_i;
  logic [NoMst-1:0]     cr_ready_o;
  logic [NoMst*5-1:0]   cr_resp_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [4:0]           resp_o;
  logic [NoMst-1:0]     data_mask_o;
  logic                 busy_o;

  // The collector itself.
  modport slave (
    input  start_valid_i, start_mask_i, cr_valid_i, cr_resp_i, resp_ready_i,
    output start_ready_o, cr_ready_o, resp_valid_o, resp_o, data_mask_o, busy_o
  );

  // Whatever drives starts and snoop responses and consumes the merged result.
  modport master (
    output start_valid_i, start_mask_i, cr_valid_i, cr_resp_i, resp_ready_i,
    input  start_ready_o, cr_ready_o, resp_valid_o, resp_o, data_mask_o, busy_o
  );
endinterface

// File: rtl/ace_ccu_snoop_resp_collect.sv
// Collects CR-channel snoop responses from every snooped port, ORs them into a
// single CRRESP (forcing Error on duplicate PassDirty) and hands it downstream.
module ace_ccu_snoop_resp_collect #(
  parameter int unsigned NoMst = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  ace_ccu_snoop_resp_collect_if.slave bus
);
  localparam int unsigned DT = 0;
  localparam int unsigned ER = 1;
  localparam int unsigned PD = 2;

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_e;

  state_e           state_q;
  logic [NoMst-1:0] pending_q;
  logic [4:0]       acc_q;
  logic [NoMst-1:0] dmask_q;
  logic             start_ready_q;
  logic             resp_valid_q;
  logic             busy_q;

  logic [NoMst-1:0] accept;
  logic [NoMst-1:0] pending_nxt;
  logic [4:0]       acc_nxt;
  logic [NoMst-1:0] dmask_nxt;
  logic             pd_seen;

  // pending_q is only non-zero in COLLECT, so it doubles as the ready vector.
  assign accept = bus.cr_valid_i & pending_q;

  // Several ports may answer in one cycle; a PassDirty from any of them on top
  // of an already-seen PassDirty flags the merged response as erroneous.
  always_comb begin
    pending_nxt = pending_q & ~accept;
    acc_nxt     = acc_q;
    dmask_nxt   = dmask_q;
    pd_seen     = acc_q[PD];
    for (int i = 0; i < int'(NoMst); i++) begin
      if (accept[i]) begin
        if (pd_seen && bus.cr_resp_i[5*i+PD]) acc_nxt[ER] = 1'b1;
        pd_seen      = pd_seen | bus.cr_resp_i[5*i+PD];
        acc_nxt      = acc_nxt | bus.cr_resp_i[5*i +: 5];
        dmask_nxt[i] = dmask_q[i] | bus.cr_resp_i[5*i+DT];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      acc_q         <= '0;
      dmask_q       <= '0;
      start_ready_q <= 1'b1;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid_i) begin
            acc_q         <= '0;
            dmask_q       <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (bus.start_mask_i != '0) begin
              pending_q <= bus.start_mask_i;
              state_q   <= COLLECT;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= OUTPUT;
            end
          end
        end
        COLLECT: begin
          pending_q <= pending_nxt;
          acc_q     <= acc_nxt;
          dmask_q   <= dmask_nxt;
          if (pending_nxt == '0) begin
            resp_valid_q <= 1'b1;
            state_q      <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.resp_ready_i) begin
            resp_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          pending_q     <= '0;
          resp_valid_q  <= 1'b0;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready_o = start_ready_q;
  assign bus.cr_ready_o    = pending_q;
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_o        = acc_q;
  assign bus.data_mask_o   = dmask_q;
  assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_ace_ccu_snoop_resp_collect.sv
// Directed-vector bench for ace_ccu_snoop_resp_collect with NoMst=4.
module tb_ace_ccu_snoop_resp_collect;
  localparam int unsigned NoMst = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ace_ccu_snoop_resp_collect_if #(.NoMst(NoMst)) bus ();

  ace_ccu_snoop_resp_collect #(.NoMst(NoMst)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs driven here apply to
  // the following edge, outputs read here reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_resp(input int port, input logic [4:0] r);
    bus.cr_resp_i[5*port +: 5] = r;
  endtask

  task automatic idle_inputs();
    bus.start_valid_i = 1'b0;
    bus.start_mask_i  = '0;
    bus.cr_valid_i    = '0;
    bus.cr_resp_i     = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, ".start_ready"}, 8'(bus.start_ready_o), 8'h1);
    check_vec({tag, ".cr_ready"},    8'(bus.cr_ready_o),    8'h0);
    check_vec({tag, ".resp_valid"},  8'(bus.resp_valid_o),  8'h0);
    check_vec({tag, ".resp"},        8'(bus.resp_o),        8'h0);
    check_vec({tag, ".data_mask"},   8'(bus.data_mask_o),   8'h0);
    check_vec({tag, ".busy"},        8'(bus.busy_o),        8'h0);
  endtask

  // Issue a start in the cycle following the call; returns after edge T.
  task automatic do_start(input logic [3:0] mask);
    bus.start_valid_i = 1'b1;
    bus.start_mask_i  = mask;
    step();
    bus.start_valid_i = 1'b0;
    bus.start_mask_i  = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.resp_ready_i = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Sparse mask, staggered responses.
    check_vec("t1.start_ready_T", 8'(bus.start_ready_o), 8'h1);
    do_start(4'b0101);
    check_vec("t1.cr_ready_T1", 8'(bus.cr_ready_o), 8'b0101);
    check_vec("t1.busy_T1", 8'(bus.busy_o), 8'h1);
    bus.cr_valid_i = 4'b0001;
    set_resp(0, 5'b00000);
    step();
    check_vec("t1.cr_ready_T2", 8'(bus.cr_ready_o), 8'b0100);
    bus.cr_valid_i = '0;
    step();
    bus.cr_valid_i = 4'b0100;
    set_resp(2, 5'b01100);
    step();
    bus.cr_valid_i = '0;
    check_vec("t1.resp_valid_T4", 8'(bus.resp_valid_o), 8'h1);
    check_vec("t1.resp_T4", 8'(bus.resp_o), 8'b01100);
    check_vec("t1.dmask_T4", 8'(bus.data_mask_o), 8'h0);
    step();
    check_vec("t1.start_ready_T5", 8'(bus.start_ready_o), 8'h1);
    check_vec("t1.resp_valid_T5", 8'(bus.resp_valid_o), 8'h0);

    // Full mask, all ports respond together.
    idle_inputs();
    do_start(4'b1111);
    bus.cr_valid_i = 4'b1111;
    set_resp(0, 5'b01000);
    set_resp(1, 5'b00001);
    set_resp(2, 5'b00000);
    set_resp(3, 5'b00001);
    step();
    bus.cr_valid_i = '0;
    check_vec("t2.cr_ready_T2", 8'(bus.cr_ready_o), 8'h0);
    check_vec("t2.resp_valid_T2", 8'(bus.resp_valid_o), 8'h1);
    check_vec("t2.resp_T2", 8'(bus.resp_o), 8'b01001);
    check_vec("t2.dmask_T2", 8'(bus.data_mask_o), 8'b1010);
    step();
    check_vec("t2.start_ready_T3", 8'(bus.start_ready_o), 8'h1);

    // Empty mask with back-pressure on the merged output.
    idle_inputs();
    bus.resp_ready_i = 1'b0;
    do_start(4'b0000);
    check_vec("t3.resp_valid_T1", 8'(bus.resp_valid_o), 8'h1);
    check_vec("t3.resp_T1", 8'(bus.resp_o), 8'h0);
    for (int c = 0; c < 5; c++) begin
      bus.start_valid_i = 1'b1;
      bus.start_mask_i  = 4'b1111;
      step();
      check_vec($sformatf("t3.hold_valid_%0d", c), 8'(bus.resp_valid_o), 8'h1);
      check_vec($sformatf("t3.hold_resp_%0d", c), 8'(bus.resp_o), 8'h0);
      check_vec($sformatf("t3.hold_sready_%0d", c), 8'(bus.start_ready_o), 8'h0);
      check_vec($sformatf("t3.hold_crready_%0d", c), 8'(bus.cr_ready_o), 8'h0);
    end
    bus.start_valid_i = 1'b0;
    bus.start_mask_i  = '0;
    bus.resp_ready_i  = 1'b1;
    step();
    check_vec("t3.start_ready_after", 8'(bus.start_ready_o), 8'h1);
    check_vec("t3.busy_after", 8'(bus.busy_o), 8'h0);

    // Non-pending port chatter and duplicate responses are ignored.
    idle_inputs();
    do_start(4'b0011);
    bus.cr_valid_i = 4'b1001;
    set_resp(0, 5'b01000);
    set_resp(3, 5'b10000);
    check_vec("t4.cr_ready_T1", 8'(bus.cr_ready_o), 8'b0011);
    step();
    check_vec("t4.cr_ready_T2", 8'(bus.cr_ready_o), 8'b0010);
    set_resp(0, 5'b10001);
    step();
    check_vec("t4.cr_ready_T3", 8'(bus.cr_ready_o), 8'b0010);
    bus.cr_valid_i = 4'b1011;
    set_resp(1, 5'b00001);
    step();
    bus.cr_valid_i = '0;
    check_vec("t4.resp_valid", 8'(bus.resp_valid_o), 8'h1);
    check_vec("t4.resp", 8'(bus.resp_o), 8'b01001);
    check_vec("t4.dmask", 8'(bus.data_mask_o), 8'b0010);
    step();

    // PassDirty from two ports in separate cycles forces Error.
    idle_inputs();
    do_start(4'b0011);
    bus.cr_valid_i = 4'b0001;
    set_resp(0, 5'b00100);
    step();
    bus.cr_valid_i = 4'b0010;
    set_resp(1, 5'b00100);
    step();
    bus.cr_valid_i = '0;
    check_vec("t5a.resp", 8'(bus.resp_o), 8'b00110);
    check_vec("t5a.resp_valid", 8'(bus.resp_valid_o), 8'h1);
    step();

    // PassDirty from two ports in the same cycle forces Error.
    idle_inputs();
    do_start(4'b1100);
    bus.cr_valid_i = 4'b1100;
    set_resp(2, 5'b00100);
    set_resp(3, 5'b00101);
    step();
    bus.cr_valid_i = '0;
    check_vec("t5b.resp", 8'(bus.resp_o), 8'b00111);
    check_vec("t5b.dmask", 8'(bus.data_mask_o), 8'b1000);
    step();

    // Single PassDirty stays clean.
    idle_inputs();
    do_start(4'b0100);
    bus.cr_valid_i = 4'b0100;
    set_resp(2, 5'b10100);
    step();
    bus.cr_valid_i = '0;
    check_vec("t5c.resp", 8'(bus.resp_o), 8'b10100);
    step();

    // Asynchronous reset in the middle of COLLECT.
    idle_inputs();
    do_start(4'b0110);
    bus.cr_valid_i = 4'b0010;
    set_resp(1, 5'b11001);
    step();
    bus.cr_valid_i = '0;
    check_vec("t6.cr_ready_mid", 8'(bus.cr_ready_o), 8'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6.async");
    step();
    rst_n = 1'b1;
    step();
    do_start(4'b0001);
    check_vec("t6.cr_ready_new", 8'(bus.cr_ready_o), 8'b0001);
    bus.cr_valid_i = 4'b0001;
    set_resp(0, 5'b00010);
    step();
    bus.cr_valid_i = '0;
    check_vec("t6.resp_new", 8'(bus.resp_o), 8'b00010);
    check_vec("t6.dmask_new", 8'(bus.data_mask_o), 8'h0);
    step();
    check_vec("t6.start_ready_end", 8'(bus.start_ready_o), 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ace_ccu_snoop_resp_collect.md
# ace_ccu_snoop_resp_collect

Receiving end of the CCU snoop path. After a snoop request is issued to a set of cached masters, this block accepts the CR-channel responses from every snooped port over valid/ready, merges them into one response, and presents it downstream on a valid/ready channel. That single merged response drives the CCU's decision to forward dirty data or fetch from memory.

## Interface
- NoMst, default 4: number of snooped master ports (≥1)
- clk_i  in  1  clock, all state updated on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_valid_i  in  1  a new snoop transaction has been issued
- start_ready_o  out  1  block is idle and can accept a transaction
- start_mask_i  in  NoMst  bit i set = port i was snooped and must respond
- cr_valid_i  in  NoMst  per-port snoop response valid
- cr_ready_o  out  NoMst  per-port snoop response ready
- cr_resp_i  in  NoMst*5  per-port CRRESP, port i at bits [5i+4:5i]: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
- resp_valid_o  out  1  merged response valid
- resp_ready_i  in  1  merged response ready
- resp_o  out  5  merged CRRESP, same bit order
- data_mask_o  out  NoMst  bit i set = port i answered with DataTransfer=1
- busy_o  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, COLLECT, OUTPUT.
- IDLE:
  - start_ready_o=1.
  - On start handshake with start_mask_i≠0: pending_q←start_mask_i, acc_q←0, dmask_q←0, go to COLLECT.
  - On start handshake with start_mask_i=0: acc_q←0, dmask_q←0, go directly to OUTPUT.
- COLLECT:
  - cr_ready_o[i]=pending_q[i].
  - Each cycle, every port with cr_valid_i[i]&&pending_q[i] is accepted. Any number of ports may be accepted in the same cycle.
  - For each accepted port: clear pending bit, acc_q |= cr_resp_i slice, dmask_q[i] |= DataTransfer bit.
  - When pending_q, after this cycle's clears, equals 0: go to OUTPUT.
- OUTPUT:
  - resp_valid_o=1, resp_o=acc_q, data_mask_o=dmask_q. All are held stable until the handshake.
  - On resp_ready_i: go to IDLE.
- Merge rule: bitwise OR of all accepted 5-bit responses.
- Protocol violation handling: if a second accepted response has PassDirty=1 while acc_q.PassDirty is already 1, the block forces the merged Error bit to 1.
- cr_valid_i on non-pending ports (never snooped, or already answered) is ignored. cr_ready_o stays 0 for those ports, and their state is unaffected.
- start_valid_i outside IDLE is not accepted. A start is only accepted in IDLE, so transactions never overlap.

## Timing
- Reset, asynchronous: state=IDLE, pending_q=0, acc_q=0, dmask_q=0.
- Output values under reset: start_ready_o=1, cr_ready_o=0, resp_valid_o=0, resp_o=0, data_mask_o=0, busy_o=0.
- Start accepted in cycle T: cr_ready_o is asserted at the earliest in cycle T+1. cr_ready_o is never combinationally dependent on start_valid_i.
- Last pending response accepted in cycle T+k: resp_valid_o=1 in cycle T+k+1.
- Empty mask: resp_valid_o=1 in T+1 with resp_o=0.
- Merged handshake in cycle U: start_ready_o=1 in U+1. The minimum transaction period is 3 cycles for a non-empty mask, 2 for an empty one.
- resp_valid_o never deasserts before the handshake, and resp_o/data_mask_o never change while resp_valid_o=1.
- cr_ready_o[i] drops in the cycle after port i's handshake. At most one response is accepted per port per transaction.
- Reset asserted mid-COLLECT or mid-OUTPUT: immediate return to the reset values. The pending transaction is discarded with no merged response.

## Test plan
- NoMst=4, mask=4'b0101. Port 0 responds 5'b00000 in T+1, port 2 responds 5'b01100 in T+3, resp_ready_i=1 -> resp_valid_o in T+4, resp_o=5'b01100, data_mask_o=0, start_ready_o=1 in T+5.
- mask=4'b1111, all four valid in T+1 with DataTransfer=1 on ports 1 and 3 -> all accepted in T+1, resp_valid_o in T+2, resp_o[0]=1, data_mask_o=4'b1010.
- mask=0 -> resp_valid_o in T+1 with resp_o=0. Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and resp_o stable, start_ready_o=0 throughout.
- mask=4'b0011, port 3 drives cr_valid_i=1 continuously, port 0 responds twice -> cr_ready_o[3]=0 throughout, second port-0 response not accepted, merge unaffected.
- Two responses both with PassDirty=1 -> resp_o={0,0,1,1,0} (Error forced). Separately, rst_ni pulsed low mid-COLLECT -> all outputs at reset values immediately, and a new start is accepted after release.
